add_pipe: RTL and testbench
===========================

Name: add_pipe

Overview:
Parametrised, pipelined two's-complement adder/subtractor, the multi-cycle successor to the combinational 16-bit adder. It splits the WIDTH-bit add into STAGES equal chunks, one chunk per pipeline stage, with the carry registered between stages. Inputs and outputs use valid/ready handshakes, so the block accepts one operation per cycle and holds its contents under backpressure. It sits between the register file and the ALU result bus wherever the combinational carry chain is too long for the target clock.

Parameters:
WIDTH, 16, operand/result width in bits; WIDTH % STAGES == 0 required (elaboration error otherwise)
STAGES, 4, pipeline depth = number of carry chunks; CHUNK = WIDTH/STAGES bits per stage; 1..WIDTH

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous active-low reset
flush  input  1  synchronous clear of all in-flight operations
in_valid  input  1  a/b/sub/cin are valid this cycle
in_ready  output  1  block accepts input this cycle
a  input  WIDTH  operand A
b  input  WIDTH  operand B
sub  input  1  0: a+b+cin; 1: a+~b+1 (cin ignored)
cin  input  1  carry-in for add mode
out_valid  output  1  result on out/cout/ovf/zero is valid
out_ready  input  1  downstream accepts result
out  output  WIDTH  sum/difference, modulo 2^WIDTH
cout  output  1  carry out of MSB (sub: 1 = no borrow, i.e. a >= b unsigned)
ovf  output  1  signed overflow
zero  output  1  out == 0

Behaviour:
- Reset (rst_n low, async): all stage valid bits 0; out, cout, ovf, zero = 0; in_ready = 1 once reset is released.
- Advance enable: en = !out_valid || out_ready. in_ready = en, combinational. When en is 0, every stage register holds; no stage advances independently.
- Accept: in_valid && in_ready on a rising edge. Stage 0 latches the operands and adds chunk 0 (bits CHUNK-1:0). Carry-in is cin in add mode and 1 in sub mode; B is bitwise inverted in sub mode.
- Stage k adds chunk k using the registered carry from stage k-1. Upper operand chunks are skewed forward unchanged. Lower result chunks are delayed to align.
- Latency: exactly STAGES cycles from the accepting edge to out_valid = 1, provided there is no stall. Throughput is one operation per cycle. STAGES=1 gives a single registered adder.
- Bubbles: if in_valid is 0 while en is 1, a 0 valid bit enters stage 0 and propagates. The data registers of a bubble stage are don't-care.
- Output regs: out, cout, ovf and zero update only on an edge where en is 1 and the final-stage input is valid. Otherwise they hold the last value. out_valid drops after a handshake unless a new result arrives on the same edge.
- Backpressure: out_valid && !out_ready freezes the whole pipeline. out, cout, ovf and zero stay stable until the handshake.
- Simultaneous output handshake and input accept on the same edge is legal. Results stay in order.
- ovf: add mode: a[MSB] == b[MSB] && out[MSB] != a[MSB]. Sub mode: a[MSB] != b[MSB] && out[MSB] != a[MSB]. Computed in the final stage from skewed MSB copies.
- flush: on the next edge, all valid bits are cleared, including out_valid. Output data regs hold. flush overrides in_valid, so no input is accepted that cycle, and it also overrides a stall.
- Reset mid-operation: all in-flight ops are discarded immediately. No partial result is ever presented.

Test Plan:
- STAGES=4, WIDTH=16, no stall. Issue back-to-back a/b pairs (0000,0000), (0000,FFFF), (FFFF,FFFF), (AAAA,5555), (33C3,0FF0), (0948,9876), sub=0, cin=0. Expect out_valid first high 4 cycles after the first accept, then on consecutive cycles. Expect out = 0000 (zero=1), FFFF, FFFE (cout=1), FFFF, 43B3, A1BE.
- Carry across every chunk boundary: 00FF+0001 -> 0100; FFFF+0000 with cin=1 -> 0000, cout=1, zero=1; 7FFF+0001 -> 8000, ovf=1, cout=0.
- Sub mode: 0000-0001 -> FFFF, cout=0; 8000-0001 -> 7FFF, ovf=1, cout=1; 1234-1234 -> 0000, zero=1, cout=1.
- Backpressure: hold out_ready=0 for 5 cycles with the pipe full. Expect in_ready=0, out stable, and no lost or duplicated results; the 6 results drain in order after release.
- flush and reset: with 3 ops in flight, pulse flush. Expect out_valid=0 next cycle, no results emerge, and out keeps its prior value. Repeat with rst_n pulsed low mid-stream: expect all outputs 0 asynchronously.
- Parameter sweep (WIDTH,STAGES) = (16,1), (32,8), (8,8): random a/b/sub/cin with random stalls vs a reference model. Expect exact match and latency equal to STAGES.

Source files
------------

// File: rtl/add_pipe.sv
// add_pipe: pipelined two's-complement adder/subtractor.
//
// The WIDTH-bit add is split into STAGES chunks of CHUNK = WIDTH/STAGES bits.
// Each pipeline stage adds one chunk and registers the chunk carry for the
// next stage. The final stage feeds the output registers directly, so a
// result appears STAGES register stages after acceptance. STAGES = 1 is a
// plain registered adder.
//
// Ports:
//   clk, rst_n     rising-edge clock, asynchronous active-low reset
//   flush          synchronous clear of every in-flight operation
//   in_valid/in_ready    input handshake for a, b, sub, cin
//   a, b           operands (WIDTH bits)
//   sub            0: a + b + cin, 1: a - b (cin ignored)
//   out_valid/out_ready  output handshake for out, cout, ovf, zero
//   out            sum/difference modulo 2^WIDTH
//   cout           carry out of the MSB (sub: 1 means no borrow)
//   ovf            signed overflow
//   zero           out == 0
module add_pipe #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);
    localparam int CHUNK = WIDTH / STAGES;

    if ((STAGES < 1) || (STAGES > WIDTH) || ((WIDTH % STAGES) != 0)) begin : g_param_check
        $error("add_pipe: WIDTH must be a multiple of STAGES with 1 <= STAGES <= WIDTH");
    end

    // Output registers (declared early: the advance enable depends on them).
    logic             out_valid_d, out_valid_q;
    logic [WIDTH-1:0] out_d, out_q;
    logic             cout_d, cout_q;
    logic             ovf_d, ovf_q;
    logic             zero_d, zero_q;

    // Global advance enable and stage-0 operand conditioning.
    logic             en;
    logic [WIDTH-1:0] b_eff;
    logic             c_in;

    always_comb begin
        en       = !out_valid_q || out_ready;
        in_ready = en;
        b_eff    = sub ? ~b : b;
        c_in     = sub ? 1'b1 : cin;
    end

    // Intermediate stages 0..STAGES-2. Stage k holds the finished low result
    // bits (lo), the untouched upper operand bits (ha/hb) and the chunk carry.
    // Register widths shrink/grow per stage so no dead bits are carried.
    for (genvar k = 0; k < STAGES - 1; k++) begin : g_st
        localparam int LO = (k + 1) * CHUNK;
        localparam int HI = WIDTH - LO;

        logic           vld_d, vld_q;
        logic           cy_d, cy_q;
        logic [LO-1:0]  lo_n, lo_d, lo_q;
        logic [HI-1:0]  ha_n, ha_d, ha_q;
        logic [HI-1:0]  hb_n, hb_d, hb_q;
        logic           src_vld;
        logic [CHUNK:0] sum;

        if (k == 0) begin : g_src
            always_comb begin
                src_vld = in_valid;
                sum     = {1'b0, a[CHUNK-1:0]} + {1'b0, b_eff[CHUNK-1:0]}
                        + {{CHUNK{1'b0}}, c_in};
                lo_n    = sum[CHUNK-1:0];
                ha_n    = a[WIDTH-1:CHUNK];
                hb_n    = b_eff[WIDTH-1:CHUNK];
            end
        end else begin : g_src
            always_comb begin
                src_vld = g_st[k-1].vld_q;
                sum     = {1'b0, g_st[k-1].ha_q[CHUNK-1:0]}
                        + {1'b0, g_st[k-1].hb_q[CHUNK-1:0]}
                        + {{CHUNK{1'b0}}, g_st[k-1].cy_q};
                lo_n    = {sum[CHUNK-1:0], g_st[k-1].lo_q};
                ha_n    = g_st[k-1].ha_q[HI+CHUNK-1:CHUNK];
                hb_n    = g_st[k-1].hb_q[HI+CHUNK-1:CHUNK];
            end
        end

        always_comb begin
            vld_d = vld_q;
            cy_d  = cy_q;
            lo_d  = lo_q;
            ha_d  = ha_q;
            hb_d  = hb_q;
            if (en) begin
                vld_d = src_vld;
                cy_d  = sum[CHUNK];
                lo_d  = lo_n;
                ha_d  = ha_n;
                hb_d  = hb_n;
            end
            // Flush wins over both new input and a stall.
            if (flush) begin
                vld_d = 1'b0;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vld_q <= 1'b0;
                cy_q  <= 1'b0;
                lo_q  <= '0;
                ha_q  <= '0;
                hb_q  <= '0;
            end else begin
                vld_q <= vld_d;
                cy_q  <= cy_d;
                lo_q  <= lo_d;
                ha_q  <= ha_d;
                hb_q  <= hb_d;
            end
        end
    end

    // Final stage: adds the top chunk straight into the output registers.
    logic             fin_vld;
    logic [CHUNK:0]   fin_sum;
    logic [WIDTH-1:0] fin_res;
    logic             fin_a_msb;
    logic             fin_b_msb;

    if (STAGES == 1) begin : g_fin
        always_comb begin
            fin_vld   = in_valid;
            fin_sum   = {1'b0, a} + {1'b0, b_eff} + {{CHUNK{1'b0}}, c_in};
            fin_res   = fin_sum[CHUNK-1:0];
            fin_a_msb = a[WIDTH-1];
            fin_b_msb = b_eff[WIDTH-1];
        end
    end else begin : g_fin
        always_comb begin
            fin_vld   = g_st[STAGES-2].vld_q;
            fin_sum   = {1'b0, g_st[STAGES-2].ha_q} + {1'b0, g_st[STAGES-2].hb_q}
                      + {{CHUNK{1'b0}}, g_st[STAGES-2].cy_q};
            fin_res   = {fin_sum[CHUNK-1:0], g_st[STAGES-2].lo_q};
            fin_a_msb = g_st[STAGES-2].ha_q[CHUNK-1];
            fin_b_msb = g_st[STAGES-2].hb_q[CHUNK-1];
        end
    end

    // With b already inverted in sub mode, both add and sub overflow reduce to
    // "operands agree in sign, result does not".
    always_comb begin
        out_valid_d = out_valid_q;
        out_d       = out_q;
        cout_d      = cout_q;
        ovf_d       = ovf_q;
        zero_d      = zero_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (en) begin
            out_valid_d = fin_vld;
            if (fin_vld) begin
                out_d  = fin_res;
                cout_d = fin_sum[CHUNK];
                ovf_d  = (fin_a_msb == fin_b_msb) && (fin_res[WIDTH-1] != fin_a_msb);
                zero_d = (fin_res == '0);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_q       <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            zero_q      <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            out_q       <= out_d;
            cout_q      <= cout_d;
            ovf_q       <= ovf_d;
            zero_q      <= zero_d;
        end
    end

    always_comb begin
        out_valid = out_valid_q;
        out       = out_q;
        cout      = cout_q;
        ovf       = ovf_q;
        zero      = zero_q;
    end

endmodule

// File: tb/tb_add_pipe.sv
module tb_add_pipe;

    // ---------------- main DUT: WIDTH=16, STAGES=4 ----------------
    logic        clk, rst_n, flush, in_valid, sub, cin, out_ready;
    logic [15:0] a, b;
    logic        in_ready, out_valid, cout, ovf, zero;
    logic [15:0] out;

    add_pipe #(.WIDTH(16), .STAGES(4)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .sub(sub), .cin(cin),
        .out_valid(out_valid), .out_ready(out_ready),
        .out(out), .cout(cout), .ovf(ovf), .zero(zero)
    );

    // ---------------- sweep DUTs (shared stimulus, no stalls) ----------------
    logic        sw_valid, sw_sub, sw_cin, sw_flush, sw_rdy;
    logic [31:0] sw_a, sw_b;

    logic        s1_ir, s1_ov, s1_c, s1_o, s1_z;
    logic [15:0] s1_out;
    logic        s2_ir, s2_ov, s2_c, s2_o, s2_z;
    logic [31:0] s2_out;
    logic        s3_ir, s3_ov, s3_c, s3_o, s3_z;
    logic [7:0]  s3_out;

    add_pipe #(.WIDTH(16), .STAGES(1)) dut_16x1 (
        .clk(clk), .rst_n(rst_n), .flush(sw_flush),
        .in_valid(sw_valid), .in_ready(s1_ir),
        .a(sw_a[15:0]), .b(sw_b[15:0]), .sub(sw_sub), .cin(sw_cin),
        .out_valid(s1_ov), .out_ready(sw_rdy),
        .out(s1_out), .cout(s1_c), .ovf(s1_o), .zero(s1_z)
    );

    add_pipe #(.WIDTH(32), .STAGES(8)) dut_32x8 (
        .clk(clk), .rst_n(rst_n), .flush(sw_flush),
        .in_valid(sw_valid), .in_ready(s2_ir),
        .a(sw_a), .b(sw_b), .sub(sw_sub), .cin(sw_cin),
        .out_valid(s2_ov), .out_ready(sw_rdy),
        .out(s2_out), .cout(s2_c), .ovf(s2_o), .zero(s2_z)
    );

    add_pipe #(.WIDTH(8), .STAGES(8)) dut_8x8 (
        .clk(clk), .rst_n(rst_n), .flush(sw_flush),
        .in_valid(sw_valid), .in_ready(s3_ir),
        .a(sw_a[7:0]), .b(sw_b[7:0]), .sub(sw_sub), .cin(sw_cin),
        .out_valid(s3_ov), .out_ready(sw_rdy),
        .out(s3_out), .cout(s3_c), .ovf(s3_o), .zero(s3_z)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Directed vector with hand-computed result.
    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic        sub;
        logic        cin;
        logic [15:0] r;
        logic        c;
        logic        o;
        logic        z;
    } vec_t;

    function automatic vec_t mk(input logic [15:0] va, input logic [15:0] vb,
                                input logic vs, input logic vc,
                                input logic [15:0] vr, input logic ec,
                                input logic eo, input logic ez);
        vec_t v;
        v.a = va; v.b = vb; v.sub = vs; v.cin = vc;
        v.r = vr; v.c = ec; v.o = eo; v.z = ez;
        return v;
    endfunction

    function automatic logic [18:0] exp_of(input vec_t v);
        return {v.c, v.o, v.z, v.r};
    endfunction

    task automatic drive(input vec_t v);
        a = v.a; b = v.b; sub = v.sub; cin = v.cin;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference arithmetic for the sweep, written from the operation's
    // definition (unsigned wide add, sign rules on the original operands).
    typedef struct packed {
        logic        c;
        logic        o;
        logic        z;
        logic [31:0] r;
    } res_t;

    function automatic res_t ref_op(input int unsigned w, input logic [31:0] ra,
                                    input logic [31:0] rb, input logic rs, input logic rc);
        res_t        res;
        logic [31:0] m, am, bm;
        logic [63:0] full;
        m    = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        am   = ra & m;
        bm   = rb & m;
        if (rs)
            full = {32'd0, am} + {32'd0, (~bm) & m} + 64'd1;
        else
            full = {32'd0, am} + {32'd0, bm} + {63'd0, rc};
        res.r = full[31:0] & m;
        res.c = full[w];
        if (rs)
            res.o = (am[w-1] != bm[w-1]) && (res.r[w-1] != am[w-1]);
        else
            res.o = (am[w-1] == bm[w-1]) && (res.r[w-1] != am[w-1]);
        res.z = (res.r == 32'd0);
        return res;
    endfunction

    vec_t        vt [12];
    logic        hv [48];
    logic [31:0] ha [48];
    logic [31:0] hb [48];
    logic        hs [48];
    logic        hc [48];

    initial begin
        int   sent, got, j;
        logic acc;
        res_t r;

        vt[0]  = mk(16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
        vt[1]  = mk(16'h0000, 16'hFFFF, 1'b0, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b0);
        vt[2]  = mk(16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 16'hFFFE, 1'b1, 1'b0, 1'b0);
        vt[3]  = mk(16'hAAAA, 16'h5555, 1'b0, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b0);
        vt[4]  = mk(16'h33C3, 16'h0FF0, 1'b0, 1'b0, 16'h43B3, 1'b0, 1'b0, 1'b0);
        vt[5]  = mk(16'h0948, 16'h9876, 1'b0, 1'b0, 16'hA1BE, 1'b0, 1'b0, 1'b0);
        vt[6]  = mk(16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0);
        vt[7]  = mk(16'hFFFF, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1);
        vt[8]  = mk(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
        vt[9]  = mk(16'h0000, 16'h0001, 1'b1, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b0);
        vt[10] = mk(16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1, 1'b0);
        vt[11] = mk(16'h1234, 16'h1234, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1);

        rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; sub = 1'b0; cin = 1'b0;
        sw_valid = 1'b0; sw_a = '0; sw_b = '0; sw_sub = 1'b0; sw_cin = 1'b0;
        sw_flush = 1'b0; sw_rdy = 1'b1;

        // Reset state
        #2 rst_n = 1'b0;
        #1;
        chk("reset_outputs", {out_valid, cout, ovf, zero, out}, 20'h0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        tick();
        chk("reset_in_ready", in_ready, 1'b1);

        // Back-to-back stream of all 12 directed vectors; first result
        // valid on the 4th edge counting the accepting one.
        for (int i = 0; i < 16; i++) begin
            in_valid = (i < 12);
            drive(vt[(i < 12) ? i : 0]);
            #1;
            chk("stream_in_ready", in_ready, 1'b1);
            tick();
            j = i - 3;
            if (j >= 0 && j < 12)
                chk($sformatf("stream_%0d", j), {out_valid, cout, ovf, zero, out},
                    {1'b1, exp_of(vt[j])});
            else
                chk($sformatf("stream_idle_%0d", i), out_valid, 1'b0);
        end

        // Backpressure: pipe fills, out_ready held low 5 cycles, then drain.
        in_valid = 1'b0;
        sent = 0; got = 0;
        for (int c = 0; c < 40 && got < 6; c++) begin
            in_valid  = (sent < 6);
            drive(vt[(sent < 6) ? sent : 0]);
            out_ready = (c >= 9);
            #1;
            if (out_valid && !out_ready) begin
                chk("bp_in_ready", in_ready, 1'b0);
                chk("bp_hold", {cout, ovf, zero, out}, exp_of(vt[got]));
            end
            if (out_valid && out_ready) begin
                chk($sformatf("bp_drain_%0d", got), {cout, ovf, zero, out}, exp_of(vt[got]));
                got++;
            end
            acc = in_valid && in_ready;
            tick();
            if (acc) sent++;
        end
        chk("bp_count", got, 6);
        in_valid = 1'b0; out_ready = 1'b1;

        // Flush with 3 ops in flight; flush also blocks the input offered with it.
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            drive(vt[6 + i]);
            tick();
        end
        flush = 1'b1; in_valid = 1'b1; drive(vt[9]);
        tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_next", {out_valid, cout, ovf, zero, out}, {1'b0, exp_of(vt[5])});
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("flush_quiet", {out_valid, cout, ovf, zero, out}, {1'b0, exp_of(vt[5])});
        end

        // Flush during a stall
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            drive(vt[2 + i]);
            tick();
        end
        chk("stall_pre_flush", {out_valid, cout, ovf, zero, out}, {1'b1, exp_of(vt[2])});
        flush = 1'b1; in_valid = 1'b1; drive(vt[6]);
        tick();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        chk("stall_flush", {out_valid, cout, ovf, zero, out}, {1'b0, exp_of(vt[2])});
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_flush_quiet", out_valid, 1'b0);
        end

        // Asynchronous reset mid-stream
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            drive(vt[2 + i]);
            tick();
        end
        drive(vt[6]);
        chk("rst_pre", {out_valid, cout, ovf, zero, out}, {1'b1, exp_of(vt[2])});
        #2 rst_n = 1'b0;
        #1;
        chk("rst_async", {out_valid, cout, ovf, zero, out}, 20'h0);
        in_valid = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        tick();
        chk("rst_in_ready", in_ready, 1'b1);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("rst_quiet", {out_valid, cout, ovf, zero, out}, 20'h0);
        end

        // Parameter sweep: random operands with input bubbles vs reference.
        for (int i = 0; i < 48; i++) begin
            hv[i] = (i < 40) && ($urandom_range(3) != 0);
            ha[i] = $urandom;
            hb[i] = $urandom;
            hs[i] = 1'($urandom_range(1));
            hc[i] = 1'($urandom_range(1));
            sw_valid = hv[i]; sw_a = ha[i]; sw_b = hb[i]; sw_sub = hs[i]; sw_cin = hc[i];
            tick();

            r = ref_op(16, ha[i], hb[i], hs[i], hc[i]);
            chk("sw16x1_ctl", {s1_ir, s1_ov}, {1'b1, hv[i]});
            if (hv[i])
                chk("sw16x1_data", {s1_c, s1_o, s1_z, 16'h0, s1_out}, r);

            j = i - 7;
            if (j >= 0) begin
                r = ref_op(32, ha[j], hb[j], hs[j], hc[j]);
                chk("sw32x8_ctl", {s2_ir, s2_ov}, {1'b1, hv[j]});
                if (hv[j])
                    chk("sw32x8_data", {s2_c, s2_o, s2_z, s2_out}, r);
                r = ref_op(8, ha[j], hb[j], hs[j], hc[j]);
                chk("sw8x8_ctl", {s3_ir, s3_ov}, {1'b1, hv[j]});
                if (hv[j])
                    chk("sw8x8_data", {s3_c, s3_o, s3_z, 24'h0, s3_out}, r);
            end else begin
                chk("sw32x8_lat", s2_ov, 1'b0);
                chk("sw8x8_lat", s3_ov, 1'b0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
